mdu_iter: RTL

- Iterative multiply/divide unit holding the HI/LO register pair for MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Sits downstream of the carry-lookahead adder tree. Its per-iteration add/subtract step is built from that adder and consumes its sum output.
- The CPU issues an operation with a start pulse, stalls on busy, and reads HI/LO once busy is low.

---
 rtl/mdu_pkg.sv | 20 ++
 rtl/mdu_addsub.sv | 28 ++
 rtl/mdu_iter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: op codes, FSM states, default width and the 4-bit lookahead carry helper for mdu_iter
package mdu_pkg;
    localparam int MDU_WIDTH = 32;
    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    typedef enum logic [1:0] {IDLE, CALC, SIGN} state_e;
    function automatic logic [3:0] cla_4(input logic [3:0] g, input logic [3:0] p, input logic ci);
        logic gg, gp;
        gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        gp = &p;
        return {gg | (gp & ci),
                g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci),
                g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci),
                g[0] | (p[0] & ci)};
    endfunction
endpackage

// File: rtl/mdu_addsub.sv
// mdu_addsub: N-bit add/subtract from cascaded 4-bit lookahead groups; sub_i inverts y_i and sets carry-in
module mdu_addsub
    import mdu_pkg::*;
#(
    parameter int N = 33
) (
    input  logic [N-1:0] x_i,
    input  logic [N-1:0] y_i,
    input  logic         sub_i,
    output logic [N-1:0] sum_o,
    output logic         co_o
);
    localparam int NG = N / 4;
    logic [N-1:0] yy, g, p;
    logic [N:0]   c;
    assign yy = y_i ^ {N{sub_i}};
    assign g  = x_i & yy;
    assign p  = x_i ^ yy;
    // group carries cascade through cla_4 blocks; leftover top bits ripple
    always_comb begin
        c    = '0;
        c[0] = sub_i;
        for (int j = 0; j < NG; j++) c[4*j+1 +: 4] = cla_4(g[4*j +: 4], p[4*j +: 4], c[4*j]);
        for (int k = 4 * NG; k < N; k++) c[k+1] = g[k] | (p[k] & c[k]);
    end
    assign sum_o = p ^ c[N-1:0];
    assign co_o  = c[N];
endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: iterative MULT/MULTU/DIV/DIVU with HI/LO; MDU_DIVZERO_EN adds early divide-by-zero and div_zero
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
`ifdef MDU_DIVZERO_EN
    ,
    output logic             div_zero
`endif
);
    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d, hi_q, hi_d, lo_q, lo_d;
    logic               is_div_q, is_div_d, neg_res_q, neg_res_d, neg_rem_q, neg_rem_d, done_q, done_d;
`ifdef MDU_DIVZERO_EN
    logic               dz_q, dz_d, dzo_q, dzo_d;
`endif
    logic               mul_op, div_op, a_neg, b_neg, add_co;
    logic [WIDTH-1:0]   a_mag, b_mag, res_hi, res_lo;
    logic [WIDTH:0]     add_x, add_s;
    logic [2*WIDTH-1:0] prod, mul_next, div_next;

    assign mul_op = (op == OP_MULT) || (op == OP_MULTU);
    assign div_op = (op == OP_DIV) || (op == OP_DIVU);
    assign a_neg  = ((op == OP_MULT) || (op == OP_DIV)) && a[WIDTH-1];
    assign b_neg  = ((op == OP_MULT) || (op == OP_DIV)) && b[WIDTH-1];
    assign a_mag  = a_neg ? -a : a;
    assign b_mag  = b_neg ? -b : b;

    assign add_x = is_div_q ? acc_q[2*WIDTH-1:WIDTH-1] : {1'b0, acc_q[2*WIDTH-1:WIDTH]};
    mdu_addsub #(.N(WIDTH + 1)) u_addsub (
        .x_i   (add_x),
        .y_i   ({1'b0, opnd_q}),
        .sub_i (is_div_q),
        .sum_o (add_s),
        .co_o  (add_co)
    );
    assign mul_next = {acc_q[0] ? add_s : {1'b0, acc_q[2*WIDTH-1:WIDTH]}, acc_q[WIDTH-1:1]};
    assign div_next = {add_co ? add_s[WIDTH-1:0] : acc_q[2*WIDTH-2:WIDTH-1], acc_q[WIDTH-2:0], add_co};

    assign prod   = neg_res_q ? -acc_q : acc_q;
    assign res_hi = is_div_q ? (neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH]) : prod[2*WIDTH-1:WIDTH];
    assign res_lo = is_div_q ? (neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]) : prod[WIDTH-1:0];

    // next state: operand capture in IDLE, one shift-add/restoring step per CALC cycle, sign fix and HI/LO write in SIGN
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        done_d    = 1'b0;
`ifdef MDU_DIVZERO_EN
        dz_d      = dz_q;
        dzo_d     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (start && op == OP_MTHI) hi_d = a;
                if (start && op == OP_MTLO) lo_d = a;
                if (start && (mul_op || div_op)) begin
                    state_d   = CALC;
                    cnt_d     = '0;
                    is_div_d  = div_op;
                    acc_d     = {{WIDTH{1'b0}}, div_op ? a_mag : b_mag};
                    opnd_d    = div_op ? b_mag : a_mag;
                    neg_res_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
`ifdef MDU_DIVZERO_EN
                    dz_d      = div_op && (b == '0);
                    if (div_op && (b == '0)) begin
                        state_d   = SIGN;
                        acc_d     = {a, {WIDTH{1'b1}}};
                        neg_res_d = 1'b0;
                        neg_rem_d = 1'b0;
                    end
`endif
                end
            end
            CALC: begin
                acc_d   = is_div_q ? div_next : mul_next;
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = (cnt_q == CNT_W'(WIDTH - 1)) ? SIGN : CALC;
            end
            SIGN: begin
                hi_d    = res_hi;
                lo_d    = res_lo;
                done_d  = 1'b1;
                state_d = IDLE;
`ifdef MDU_DIVZERO_EN
                dzo_d   = dz_q;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // state and datapath registers; reset aborts any operation and clears HI/LO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            done_q    <= 1'b0;
`ifdef MDU_DIVZERO_EN
            dz_q      <= 1'b0;
            dzo_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            done_q    <= done_d;
`ifdef MDU_DIVZERO_EN
            dz_q      <= dz_d;
            dzo_q     <= dzo_d;
`endif
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
`ifdef MDU_DIVZERO_EN
    assign div_zero = dzo_q;
`endif
endmodule
